id_stall_sequencer: RTL and testbench



---
 rtl/id_stall_sequencer.sv | 126 ++++++++++++
 tb/tb_id_stall_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/id_stall_sequencer.sv
// ID-stage hazard stall sequencer: detects load-use and branch-operand hazards and holds PC/IF-ID for 1 or 2 cycles.
// Optional stall-cycle performance counter is built when HAZARD_PERF_CNT_EN is defined.
module id_stall_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        ID_is_branch,
    input  logic        ID_EX_RegWrite,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rd,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        kill,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Flush,
    output logic        stall_active,
    output logic [31:0] stall_cycles
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned REM_W = 2;
    localparam int unsigned CNT_W = 32;

    typedef enum logic {IDLE, STALL} state_t;

    state_t           state, state_nx;
    logic [REM_W-1:0] rem, rem_nx;
    logic [1:0]       need_c;
    logic             stall_c;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

    // $0 never creates a dependency, and an unused operand cannot stall
    assign ex_hit_rs  = ID_uses_rs && (ID_rs != REG_W'(0)) && (ID_rs == ID_EX_rd);
    assign ex_hit_rt  = ID_uses_rt && (ID_rt != REG_W'(0)) && (ID_rt == ID_EX_rd);
    assign mem_hit_rs = ID_uses_rs && (ID_rs != REG_W'(0)) && (ID_rs == EX_MEM_rd);
    assign mem_hit_rt = ID_uses_rt && (ID_rt != REG_W'(0)) && (ID_rt == EX_MEM_rd);

    // Required bubble count, first matching rule wins
    always_comb begin
        need_c = 2'd0;
        if (ID_is_branch) begin
            if (ID_EX_MemRead && (ex_hit_rs || ex_hit_rt))
                need_c = 2'd2;
            else if (ID_EX_RegWrite && (ex_hit_rs || ex_hit_rt))
                need_c = 2'd1;
            else if (EX_MEM_MemRead && (mem_hit_rs || mem_hit_rt))
                need_c = 2'd1;
            else if (EX_MEM_RegWrite && !EX_MEM_MemRead && mem_hit_rt)
                need_c = 2'd1;  // rt has no EX/MEM forwarding path
        end else if (ID_EX_MemRead && (ex_hit_rs || ex_hit_rt)) begin
            need_c = 2'd1;
        end
    end

    // Next state and stall decision; kill overrides everything
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        stall_c  = 1'b0;
        if (kill) begin
            state_nx = IDLE;
            rem_nx   = REM_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (need_c != 2'd0) begin
                        stall_c = 1'b1;
                        if (need_c == 2'd2) begin
                            state_nx = STALL;
                            rem_nx   = REM_W'(1);
                        end
                    end
                end
                STALL: begin
                    stall_c = 1'b1;
                    rem_nx  = (rem != REM_W'(0)) ? rem - REM_W'(1) : REM_W'(0);
                    if (rem <= REM_W'(1))
                        state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    rem_nx   = REM_W'(0);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rem   <= REM_W'(0);
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

    // Outputs fall back to free-running values while reset is held
    assign stall_active = stall_c & reset_n;
    assign PC_Write     = ~stall_active;
    assign IF_ID_Write  = ~stall_active;
    assign ID_EX_Flush  = stall_active;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of stall cycles that were not aborted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= CNT_W'(0);
        else if (stall_active && !kill && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end

    assign stall_cycles = cnt;
`else
    assign stall_cycles = CNT_W'(0);
`endif

endmodule

// File: tb/tb_id_stall_sequencer.sv
// Directed self-checking bench for id_stall_sequencer; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_id_stall_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  ID_rs, ID_rt, ID_EX_rd, EX_MEM_rd;
    logic        ID_uses_rs, ID_uses_rt, ID_is_branch;
    logic        ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_RegWrite, EX_MEM_MemRead;
    logic        kill;
    logic        PC_Write, IF_ID_Write, ID_EX_Flush, stall_active;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] FREE = 4'b1100;
    localparam logic [3:0] STL  = 4'b0011;

    id_stall_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_is_branch(ID_is_branch),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
        .kill(kill),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
        .stall_active(stall_active), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ce(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 32'(v);
`else
        return 32'(v - v);
`endif
    endfunction

    function automatic logic [31:0] outs();
        return 32'({PC_Write, IF_ID_Write, ID_EX_Flush, stall_active});
    endfunction

    task automatic set_hz(input logic br, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt,
                          input logic exw, input logic exr, input logic [4:0] exrd,
                          input logic mw, input logic mr, input logic [4:0] mrd,
                          input logic k);
        ID_is_branch = br; ID_rs = rs; ID_uses_rs = urs; ID_rt = rt; ID_uses_rt = urt;
        ID_EX_RegWrite = exw; ID_EX_MemRead = exr; ID_EX_rd = exrd;
        EX_MEM_RegWrite = mw; EX_MEM_MemRead = mr; EX_MEM_rd = mrd; kill = k;
    endtask

    task automatic clr();
        set_hz(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance to just after the next rising edge; inputs are then applied and outputs sampled mid-cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input string tag, input logic [3:0] exp);
        #3;
        check(tag, outs(), 32'(exp));
    endtask

    initial begin
        reset_n = 1'b0;
        // hazard present while in reset: outputs must still be free
        set_hz(0, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0);
        #12;
        check("reset_outs", outs(), 32'(FREE));
        check("reset_cnt", stall_cycles, 32'd0);
        clr();
        @(negedge clk);
        reset_n = 1'b1;

        // load-use: one bubble
        step(); set_hz(0, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0); settle_check("ldu_T", STL);
        step(); clr(); settle_check("ldu_T1", FREE);
        check("ldu_cnt", stall_cycles, ce(1));

        // branch after load, inputs held through the stall: two bubbles
        step(); set_hz(1, 0, 0, 8, 1, 1, 1, 8, 0, 0, 0, 0); settle_check("brld_T", STL);
        step(); settle_check("brld_T1", STL);
        step(); clr(); settle_check("brld_T2", FREE);
        check("brld_cnt", stall_cycles, ce(3));

        // second cycle of a 2-bubble stall ignores hazard inputs
        step(); set_hz(1, 9, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0); settle_check("ign_T", STL);
        step(); clr(); settle_check("ign_T1", STL);
        step(); settle_check("ign_T2", FREE);
        check("ign_cnt", stall_cycles, ce(5));

        // branch rt vs EX/MEM ALU result: one bubble; same on rs forwards
        step(); set_hz(1, 0, 0, 3, 1, 0, 0, 0, 1, 0, 3, 0); settle_check("rt_mem_T", STL);
        step(); clr(); settle_check("rt_mem_T1", FREE);
        step(); set_hz(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 3, 0); settle_check("rs_mem_fwd", FREE);

        // branch vs EX ALU result and vs MEM-stage load: one bubble each
        step(); set_hz(1, 7, 1, 0, 0, 1, 0, 7, 0, 0, 0, 0); settle_check("br_exalu", STL);
        step(); set_hz(1, 0, 0, 6, 1, 0, 0, 0, 1, 1, 6, 0); settle_check("br_memld", STL);
        step(); clr(); settle_check("br_memld_T1", FREE);
        check("br_cnt", stall_cycles, ce(8));

        // no stall: $0, ALU producer for non-branch, unused operand, kill on detect
        step(); set_hz(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0); settle_check("reg0", FREE);
        step(); set_hz(0, 4, 1, 0, 0, 1, 0, 4, 0, 0, 0, 0); settle_check("alu_fwd", FREE);
        step(); set_hz(0, 4, 0, 4, 0, 1, 1, 4, 0, 0, 0, 0); settle_check("unused", FREE);
        step(); set_hz(0, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 1); settle_check("kill_det", FREE);
        step(); clr(); settle_check("kill_det_T1", FREE);
        check("nostall_cnt", stall_cycles, ce(8));

        // back-to-back single bubbles with no gap
        step(); set_hz(0, 5, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0); settle_check("b2b_T", STL);
        step(); set_hz(0, 0, 0, 12, 1, 1, 1, 12, 0, 0, 0, 0); settle_check("b2b_T1", STL);
        step(); clr(); settle_check("b2b_T2", FREE);
        check("b2b_cnt", stall_cycles, ce(10));

        // kill in the second cycle of a 2-bubble stall aborts it
        step(); set_hz(1, 8, 1, 0, 0, 1, 1, 8, 0, 0, 0, 0); settle_check("abort_T", STL);
        step(); kill = 1'b1; settle_check("abort_T1", FREE);
        step(); clr(); settle_check("abort_T2", FREE);
        check("abort_cnt", stall_cycles, ce(11));

        // reset asserted during STALL
        step(); set_hz(1, 8, 1, 0, 0, 1, 1, 8, 0, 0, 0, 0); settle_check("rst_T", STL);
        step(); reset_n = 1'b0; #1;
        check("rst_mid_outs", outs(), 32'(FREE));
        check("rst_mid_cnt", stall_cycles, 32'd0);
        clr();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); set_hz(0, 5'(i + 1), 1, 5'(i + 2), 1, 1, 0, 5'(i + 1), 1, 0, 5'(i + 1), 0);
            settle_check($sformatf("post_rst_%0d", i), FREE);
        end
        check("post_rst_cnt", stall_cycles, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
